bcd_conversion_controller: RTL and testbench

//  Sequential (shift-and-add-3) binary-to-BCD converter with its controlling FSM.

---
 rtl/bcd_pkg.sv | 15 +
 rtl/bcd_add3_digit.sv | 11 +
 rtl/bcd_conversion_controller.sv | 117 +++++++++++
 tb/tb_bcd_conversion_controller.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  typedef logic [3:0] bcd_digit_t;

  // Digits at or above this value get +3 before the next left shift.
  localparam bcd_digit_t ADD3_THRESH = 4'd5;

endpackage

// File: rtl/bcd_add3_digit.sv
// One double-dabble correction cell: adds 3 to a digit that would overflow past 9 on the next shift.
module bcd_add3_digit
  import bcd_pkg::*;
(
  input  bcd_digit_t digit,
  output bcd_digit_t adjusted_c
);

  assign adjusted_c = (digit >= ADD3_THRESH) ? bcd_digit_t'(digit + 4'd3) : digit;

endmodule

// File: rtl/bcd_conversion_controller.sv
// Shift-and-add-3 binary-to-BCD converter: one iteration per clock, registered result and status.
module bcd_conversion_controller
  import bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      bin,
  input  logic                  start,
  input  logic                  auto,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int unsigned BCDW = 4 * DIGITS;
  localparam int unsigned CW   = $clog2(WIDTH + 1);
  localparam longint unsigned MAX_BIN   = (64'd1 << WIDTH) - 64'd1;
  localparam longint unsigned DEC_RANGE = 64'd10 ** DIGITS;

  // Reject parameter sets where the result cannot hold the largest operand.
  if (WIDTH < 1) begin : g_bad_width
    $error("bcd_conversion_controller: WIDTH must be at least 1");
  end
  if (DEC_RANGE <= MAX_BIN) begin : g_bad_digits
    $error("bcd_conversion_controller: DIGITS too small for WIDTH");
  end

  bcd_state_t        state_q, state_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [BCDW-1:0]   scratch_q, scratch_d;
  logic [CW-1:0]     count_q, count_d;
  logic [WIDTH-1:0]  last_bin_q, last_bin_d;
  logic              busy_d, done_d;
  logic [BCDW-1:0]   bcd_d;
  logic [BCDW-1:0]   adjusted_c;
  logic [BCDW+WIDTH-1:0] shift_c;
  logic              trigger_c;

  // Per-digit add-3 correction on the scratch register, all digits in parallel.
  for (genvar k = 0; k < DIGITS; k++) begin : g_add3
    bcd_add3_digit u_add3 (
      .digit      (scratch_q[4*k +: 4]),
      .adjusted_c (adjusted_c[4*k +: 4])
    );
  end

  // Corrected scratch and operand shifted left together as one word.
  assign shift_c   = {adjusted_c, shreg_q} << 1;
  assign trigger_c = start | (auto & (bin != last_bin_q));

  // Next-state and datapath logic.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    scratch_d  = scratch_q;
    count_d    = count_q;
    last_bin_d = last_bin_q;
    bcd_d      = bcd;
    case (state_q)
      IDLE: begin
        if (trigger_c) begin
          shreg_d    = bin;
          scratch_d  = '0;
          count_d    = CW'(WIDTH - 1);
          last_bin_d = bin;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = shift_c[BCDW+WIDTH-1:WIDTH];
        shreg_d   = shift_c[WIDTH-1:0];
        if (count_q == '0) begin
          // Publish the final shift's result so bcd is valid in the same cycle as done.
          bcd_d   = shift_c[BCDW+WIDTH-1:WIDTH];
          state_d = DONE;
        end else begin
          count_d = CW'(count_q - CW'(1));
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State, datapath and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      scratch_q  <= '0;
      count_q    <= '0;
      last_bin_q <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bcd        <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      scratch_q  <= scratch_d;
      count_q    <= count_d;
      last_bin_q <= last_bin_d;
      busy       <= busy_d;
      done       <= done_d;
      bcd        <= bcd_d;
    end
  end

endmodule

// File: tb/tb_bcd_conversion_controller.sv
// Directed bench for bcd_conversion_controller at WIDTH=8/DIGITS=3 and WIDTH=4/DIGITS=2.
module tb_bcd_conversion_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] bin8;
  logic       start8, auto8, busy8, done8;
  logic [11:0] bcd8;
  logic [3:0] bin4;
  logic       start4, auto4, busy4, done4;
  logic [7:0] bcd4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bcd_conversion_controller #(.WIDTH(8), .DIGITS(3)) u_dut8 (
    .clk(clk), .rst(rst), .bin(bin8), .start(start8), .auto(auto8),
    .busy(busy8), .done(done8), .bcd(bcd8)
  );

  bcd_conversion_controller #(.WIDTH(4), .DIGITS(2)) u_dut4 (
    .clk(clk), .rst(rst), .bin(bin4), .start(start4), .auto(auto4),
    .busy(busy4), .done(done4), .bcd(bcd4)
  );

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] bcd;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start pulse, then count cycles until done; returns to IDLE before exiting.
  task automatic conv8(input logic [7:0] b, output int lat, output logic [11:0] res);
    bin8 = b; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = -1;
    for (int n = 1; n <= 30; n++) begin
      if (done8) begin lat = n; break; end
      tick();
    end
    res = bcd8;
    tick();
  endtask

  task automatic conv4(input logic [3:0] b, output int lat, output logic [7:0] res);
    bin4 = b; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    lat = -1;
    for (int n = 1; n <= 30; n++) begin
      if (done4) begin lat = n; break; end
      tick();
    end
    res = bcd4;
    tick();
  endtask

  initial begin
    int lat, ndone, first, second;
    logic [11:0] res8;
    logic [7:0]  res4;
    logic [7:0]  exp4;
    logic        seen;

    vecs[0] = '{8'd255, 12'h255};
    vecs[1] = '{8'd0,   12'h000};
    vecs[2] = '{8'd109, 12'h109};
    vecs[3] = '{8'd1,   12'h001};
    vecs[4] = '{8'd99,  12'h099};
    vecs[5] = '{8'd100, 12'h100};
    vecs[6] = '{8'd128, 12'h128};
    vecs[7] = '{8'd10,  12'h010};
    vecs[8] = '{8'd254, 12'h254};

    rst = 1'b1;
    bin8 = '0; start8 = 1'b0; auto8 = 1'b0;
    bin4 = '0; start4 = 1'b0; auto4 = 1'b0;
    tick();
    tick();
    check("reset busy8", 32'(busy8), 32'd0);
    check("reset done8", 32'(done8), 32'd0);
    check("reset bcd8",  32'(bcd8),  32'd0);
    check("reset busy4", 32'(busy4), 32'd0);
    check("reset bcd4",  32'(bcd4),  32'd0);
    rst = 1'b0;
    tick();

    // Max operand: busy over cycles 1..9, done only at 9.
    bin8 = 8'd255; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      check($sformatf("t1 busy c%0d", k), 32'(busy8), (k <= 9) ? 32'd1 : 32'd0);
      check($sformatf("t1 done c%0d", k), 32'(done8), (k == 9) ? 32'd1 : 32'd0);
      if (k == 9) check("t1 bcd", 32'(bcd8), 32'h255);
      tick();
    end

    // Table of operands with hand-computed BCD results.
    for (int i = 0; i < 9; i++) begin
      conv8(vecs[i].bin, lat, res8);
      check($sformatf("vec%0d bcd", i), 32'(res8), 32'(vecs[i].bcd));
      check($sformatf("vec%0d latency", i), 32'(lat), 32'd9);
    end

    // Operand change and start while busy are ignored.
    bin8 = 8'd42; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    bin8 = 8'd99; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    ndone = 0; first = -1; res8 = '0;
    for (int c = 4; c <= 30; c++) begin
      if (done8) begin
        ndone++;
        if (first < 0) first = c;
        res8 = bcd8;
      end
      tick();
    end
    check("t3 done count", 32'(ndone), 32'd1);
    check("t3 done cycle", 32'(first), 32'd9);
    check("t3 bcd", 32'(res8), 32'h042);

    // Auto mode: each operand change converts once, steady operand stays quiet.
    auto8 = 1'b1; bin8 = 8'd17;
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (done8) begin seen = 1'b1; break; end
    end
    check("t4 first auto done", 32'(seen), 32'd1);
    check("t4 bcd 17", 32'(bcd8), 32'h017);
    tick();
    bin8 = 8'd200;
    ndone = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (done8) ndone++;
    end
    check("t4 done count", 32'(ndone), 32'd1);
    check("t4 bcd", 32'(bcd8), 32'h200);
    auto8 = 1'b0;
    tick();

    // Reset mid-conversion clears everything, no late done.
    bin8 = 8'd250; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    rst = 1'b1;
    tick();
    check("t5 busy", 32'(busy8), 32'd0);
    check("t5 done", 32'(done8), 32'd0);
    check("t5 bcd",  32'(bcd8),  32'd0);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (done8) ndone++;
    end
    check("t5 no done", 32'(ndone), 32'd0);
    check("t5 bcd held", 32'(bcd8), 32'd0);

    // Narrow instance: full operand sweep.
    for (int v = 0; v < 16; v++) begin
      conv4(4'(v), lat, res4);
      exp4 = 8'(((v / 10) << 4) | (v % 10));
      check($sformatf("w4 bcd %0d", v), 32'(res4), 32'(exp4));
      check($sformatf("w4 latency %0d", v), 32'(lat), 32'd5);
    end

    // Start held high: conversions repeat every WIDTH+2 cycles.
    bin4 = 4'd9; start4 = 1'b1;
    first = -1; second = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (done4) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
    end
    start4 = 1'b0;
    check("w4 held period", 32'(second - first), 32'd6);
    check("w4 held bcd", 32'(bcd4), 32'h09);
    for (int c = 0; c < 10; c++) tick();
    check("w4 idle after release", 32'(busy4), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
